seq_det_prog: RTL and testbench

Parametrised Mealy serial sequence detector. It generalises the fixed 4-bit 1100 detectors to a runtime-programmable pattern of 1..MAX_LEN bits, with runtime-selectable overlapping or non-overlapping detection and an input-valid qualifier. It sits on a serial bit stream and emits a one-cycle registered match pulse. An optional saturating match counter is available.

---
 rtl/seq_det_prog.sv | 123 ++++++++++++
 tb/tb_seq_det_prog.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_prog.sv
// Runtime-programmable Mealy serial sequence detector (1..MAX_LEN bits, overlap select).
// Optional saturating match counter enabled by defining SEQ_DET_CNT_EN.
module seq_det_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_1100),
    parameter logic [LEN_W-1:0]   RST_LEN     = LEN_W'(4),
    parameter logic               RST_OVERLAP = 1'b1
`ifdef SEQ_DET_CNT_EN
    ,
    parameter int                 CNT_W       = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i,
    input  logic               in_valid,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               q
`ifdef SEQ_DET_CNT_EN
    ,
    output logic [CNT_W-1:0]   match_cnt
`endif
);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               q_q, q_d;

    logic [MAX_LEN-1:0] nh;
    logic [LEN_W-1:0]   nf;
    logic               len_ok;
    logic               pat_eq;
    logic               match;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    // Candidate history/fill if the current bit were accepted.
    always_comb begin
        nh     = {hist_q[MAX_LEN-2:0], i};
        nf     = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
        len_ok = (len_q != '0) && (int'(len_q) <= MAX_LEN);
        pat_eq = 1'b1;
        for (int k = 0; k < MAX_LEN; k++) begin
            if ((k < int'(len_q)) && (nh[k] != pat_q[k])) begin
                pat_eq = 1'b0;
            end
        end
        match  = len_ok && (nf >= len_q) && pat_eq;
    end

    always_comb begin
        // NOTE: every _d gets a hold/default value first so no path leaves it unassigned (no latches).
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        q_d    = 1'b0;
`ifdef SEQ_DET_CNT_EN
        cnt_d  = cnt_q;
`endif
        if (cfg_we) begin
            // A config write starts a fresh search and drops any bit offered this cycle.
            pat_d  = cfg_pattern;
            len_d  = cfg_len;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
`ifdef SEQ_DET_CNT_EN
            cnt_d  = '0;
`endif
        end else if (in_valid) begin
            hist_d = nh;
            q_d    = match;
            fill_d = (!ovl_q && match) ? '0 : nf;
`ifdef SEQ_DET_CNT_EN
            if (match && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= RST_PATTERN;
            len_q  <= RST_LEN;
            ovl_q  <= RST_OVERLAP;
            q_q    <= 1'b0;
`ifdef SEQ_DET_CNT_EN
            cnt_q  <= '0;
`endif
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            q_q    <= q_d;
`ifdef SEQ_DET_CNT_EN
            cnt_q  <= cnt_d;
`endif
        end
    end

    assign q = q_q;
`ifdef SEQ_DET_CNT_EN
    assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed self-checking bench for seq_det_prog; exercises counter checks when SEQ_DET_CNT_EN is defined.
module tb_seq_det_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       i;
    logic       in_valid;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       q;
`ifdef SEQ_DET_CNT_EN
    logic [1:0] match_cnt;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    seq_det_prog #(
        .MAX_LEN(8)
`ifdef SEQ_DET_CNT_EN
        ,
        .CNT_W(2)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i          (i),
        .in_valid   (in_valid),
        .cfg_we     (cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .q          (q)
`ifdef SEQ_DET_CNT_EN
        ,
        .match_cnt  (match_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Drive one cycle of input, return q sampled 1 time unit after the edge.
    task automatic send(input logic v, input logic b, output logic qo);
        in_valid = v;
        i        = b;
        @(posedge clk);
        #1;
        qo       = q;
        in_valid = 1'b0;
        i        = 1'b0;
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic ov);
        cfg_we      = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        @(posedge clk);
        #1;
        cfg_we      = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (q !== 1'b0) $display("FAIL reset_q: q=%b expected 0", q);
        else pass_cnt++;
`ifdef SEQ_DET_CNT_EN
        total_cnt++;
        if (match_cnt !== 2'd0) $display("FAIL reset_cnt: match_cnt=%0d expected 0", match_cnt);
        else pass_cnt++;
`endif
        rst = 1'b0;
    endtask

    task automatic test_default();
        logic [7:0] bits = 8'b1100_1100;
        logic [7:0] exp  = 8'b0001_0001;
        logic qo;
        for (int k = 7; k >= 0; k--) begin
            send(1'b1, bits[k], qo);
            total_cnt++;
            if (qo !== exp[k]) $display("FAIL default bit%0d: q=%b expected %b", 8 - k, qo, exp[k]);
            else pass_cnt++;
        end
`ifdef SEQ_DET_CNT_EN
        total_cnt++;
        if (match_cnt !== 2'd2) $display("FAIL default_cnt: match_cnt=%0d expected 2", match_cnt);
        else pass_cnt++;
`endif
    endtask

    task automatic test_overlap();
        logic [5:0] bits   = 6'b101010;
        logic [5:0] exp_ov = 6'b000101;
        logic [5:0] exp_no = 6'b000100;
        logic qo;
        do_cfg(8'b0000_1010, 4'd4, 1'b1);
`ifdef SEQ_DET_CNT_EN
        total_cnt++;
        if (match_cnt !== 2'd0) $display("FAIL cfg_clears_cnt: match_cnt=%0d expected 0", match_cnt);
        else pass_cnt++;
`endif
        for (int k = 5; k >= 0; k--) begin
            send(1'b1, bits[k], qo);
            total_cnt++;
            if (qo !== exp_ov[k]) $display("FAIL overlap bit%0d: q=%b expected %b", 6 - k, qo, exp_ov[k]);
            else pass_cnt++;
        end
        do_cfg(8'b0000_1010, 4'd4, 1'b0);
        for (int k = 5; k >= 0; k--) begin
            send(1'b1, bits[k], qo);
            total_cnt++;
            if (qo !== exp_no[k]) $display("FAIL nonoverlap bit%0d: q=%b expected %b", 6 - k, qo, exp_no[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_gap();
        logic [2:0] bits = 3'b110;
        logic qo;
        do_cfg(8'b0000_1100, 4'd4, 1'b1);
        for (int k = 2; k >= 0; k--) begin
            send(1'b1, bits[k], qo);
            total_cnt++;
            if (qo !== 1'b0) $display("FAIL gap_prefix bit%0d: q=%b expected 0", 3 - k, qo);
            else pass_cnt++;
        end
        for (int k = 0; k < 3; k++) begin
            send(1'b0, 1'b0, qo);
            total_cnt++;
            if (qo !== 1'b0) $display("FAIL gap_idle cycle%0d: q=%b expected 0", k, qo);
            else pass_cnt++;
        end
        send(1'b1, 1'b0, qo);
        total_cnt++;
        if (qo !== 1'b1) $display("FAIL gap_final: q=%b expected 1", qo);
        else pass_cnt++;
    endtask

    task automatic test_cfg_collision();
        logic [2:0] pre  = 3'b110;
        logic [4:0] bits = 5'b01100;
        logic [4:0] exp  = 5'b00001;
        logic qo;
        do_cfg(8'b0000_1100, 4'd4, 1'b1);
        for (int k = 2; k >= 0; k--) send(1'b1, pre[k], qo);
        // Config write and a valid final bit land on the same edge.
        cfg_we      = 1'b1;
        cfg_pattern = 8'b0000_1100;
        cfg_len     = 4'd4;
        cfg_overlap = 1'b1;
        send(1'b1, 1'b0, qo);
        cfg_we      = 1'b0;
        total_cnt++;
        if (qo !== 1'b0) $display("FAIL collision_edge: q=%b expected 0", qo);
        else pass_cnt++;
        for (int k = 4; k >= 0; k--) begin
            send(1'b1, bits[k], qo);
            total_cnt++;
            if (qo !== exp[k]) $display("FAIL collision_after bit%0d: q=%b expected %b", 5 - k, qo, exp[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_disabled();
        logic [3:0] bits = 4'b1101;
        logic [3:0] exp  = 4'b1101;
        logic qo;
        int   seen;
        do_cfg(8'hFF, 4'd0, 1'b1);
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            send(1'b1, (k < 8) ? 1'b1 : 1'b0, qo);
            if (qo !== 1'b0) seen++;
        end
        total_cnt++;
        if (seen != 0) $display("FAIL len0_disabled: pulses=%0d expected 0", seen);
        else pass_cnt++;
        do_cfg(8'hFF, 4'd9, 1'b1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            send(1'b1, 1'b1, qo);
            if (qo !== 1'b0) seen++;
        end
        total_cnt++;
        if (seen != 0) $display("FAIL len9_disabled: pulses=%0d expected 0", seen);
        else pass_cnt++;
        do_cfg(8'b0000_0001, 4'd1, 1'b0);
        for (int k = 3; k >= 0; k--) begin
            send(1'b1, bits[k], qo);
            total_cnt++;
            if (qo !== exp[k]) $display("FAIL len1 bit%0d: q=%b expected %b", 4 - k, qo, exp[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] b_ov = 3'b111;
        logic [2:0] e_ov = 3'b011;
        logic [3:0] b_no = 4'b1111;
        logic [3:0] e_no = 4'b0101;
        logic [5:0] b_mk = 6'b110110;
        logic [5:0] e_mk = 6'b001001;
        logic qo;
        do_cfg(8'b0000_0011, 4'd2, 1'b1);
        for (int k = 2; k >= 0; k--) begin
            send(1'b1, b_ov[k], qo);
            total_cnt++;
            if (qo !== e_ov[k]) $display("FAIL b2b_overlap bit%0d: q=%b expected %b", 3 - k, qo, e_ov[k]);
            else pass_cnt++;
        end
        do_cfg(8'b0000_0011, 4'd2, 1'b0);
        for (int k = 3; k >= 0; k--) begin
            send(1'b1, b_no[k], qo);
            total_cnt++;
            if (qo !== e_no[k]) $display("FAIL b2b_nonoverlap bit%0d: q=%b expected %b", 4 - k, qo, e_no[k]);
            else pass_cnt++;
        end
        // Upper pattern bits are junk; only the low 3 (110) matter.
        do_cfg(8'b1010_1110, 4'd3, 1'b1);
        for (int k = 5; k >= 0; k--) begin
            send(1'b1, b_mk[k], qo);
            total_cnt++;
            if (qo !== e_mk[k]) $display("FAIL len_mask bit%0d: q=%b expected %b", 6 - k, qo, e_mk[k]);
            else pass_cnt++;
        end
    endtask

`ifdef SEQ_DET_CNT_EN
    task automatic test_saturation();
        logic [3:0] bits = 4'b1100;
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic qo;
        do_rst();
        for (int m = 0; m < 5; m++) begin
            for (int k = 3; k >= 0; k--) send(1'b1, bits[k], qo);
            total_cnt++;
            if (qo !== 1'b1) $display("FAIL sat_pulse match%0d: q=%b expected 1", m + 1, qo);
            else pass_cnt++;
            total_cnt++;
            if (match_cnt !== exp_cnt[m])
                $display("FAIL sat_cnt match%0d: match_cnt=%0d expected %0d", m + 1, match_cnt, exp_cnt[m]);
            else pass_cnt++;
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [2:0] pre  = 3'b101;
        logic [3:0] bits = 4'b1100;
        logic [3:0] exp  = 4'b0001;
        logic qo;
        do_cfg(8'b0000_1010, 4'd4, 1'b1);
        for (int k = 2; k >= 0; k--) send(1'b1, pre[k], qo);
        do_rst();
        total_cnt++;
        if (q !== 1'b0) $display("FAIL rst_mid_q: q=%b expected 0", q);
        else pass_cnt++;
`ifdef SEQ_DET_CNT_EN
        total_cnt++;
        if (match_cnt !== 2'd0) $display("FAIL rst_mid_cnt: match_cnt=%0d expected 0", match_cnt);
        else pass_cnt++;
`endif
        // With the old pattern and history this 0 would complete 1010.
        send(1'b1, 1'b0, qo);
        total_cnt++;
        if (qo !== 1'b0) $display("FAIL rst_mid_stale: q=%b expected 0", qo);
        else pass_cnt++;
        for (int k = 3; k >= 0; k--) begin
            send(1'b1, bits[k], qo);
            total_cnt++;
            if (qo !== exp[k]) $display("FAIL rst_mid_restore bit%0d: q=%b expected %b", 4 - k, qo, exp[k]);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst         = 1'b1;
        i           = 1'b0;
        in_valid    = 1'b0;
        cfg_we      = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;

        test_reset();
        test_default();
        test_overlap();
        test_gap();
        test_cfg_collision();
        test_disabled();
        test_back_to_back();
`ifdef SEQ_DET_CNT_EN
        test_saturation();
`endif
        test_reset_mid();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
